// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 read scheduler: FSM encoding and
// millisecond-to-cycle conversion.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    ARM,
    WAIT_DONE,
    FAIL
  } state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/dht11_scheduler_if.sv
// Handshake between the read scheduler (master) and the DHT11
// single-wire transaction engine (slave).
interface dht11_scheduler_if;
  logic       dht_start;
  logic       dht_en;
  logic       dht_abort;
  logic       dht_done;
  logic       dht_valid;
  logic [7:0] dht_rh;
  logic [7:0] dht_t;

  modport master (
    output dht_start, dht_en, dht_abort,
    input  dht_done, dht_valid, dht_rh, dht_t
  );

  modport slave (
    input  dht_start, dht_en, dht_abort,
    output dht_done, dht_valid, dht_rh, dht_t
  );
endinterface

// File: rtl/tick_gen_1ms.sv
// Free-running divider producing a registered 1-cycle pulse once per
// millisecond of system clock.
module tick_gen_1ms
  import dht11_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = ms_to_cycles(CLK_HZ, 1);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_scheduler.sv
// Periodic/forced read sequencer for the DHT11 engine with minimum-gap
// enforcement, checksum retries, timeout abort and last-good hold.
module dht11_scheduler
  import dht11_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int MIN_GAP_MS = 1000,
  parameter int TIMEOUT_MS = 30,
  parameter int MAX_RETRY  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               force_req,
  dht11_scheduler_if.master  eng,
  output logic [7:0]         rh_out,
  output logic [7:0]         t_out,
  output logic               data_valid,
  output logic               sample_stb,
  output logic               err_stb,
  output logic [7:0]         err_cnt,
  output logic               busy
);

  localparam int GW = $clog2(PERIOD_MS + 1);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [GW-1:0] PERIOD_C = GW'(PERIOD_MS);
  localparam logic [GW-1:0] MIN_C    = GW'(MIN_GAP_MS);
  localparam logic [TW-1:0] TO_C     = TW'(TIMEOUT_MS);
  localparam logic [RW-1:0] RMAX     = RW'(MAX_RETRY);

  state_t        state, state_n;
  logic          tick;
  logic [GW-1:0] gap_ms;
  logic [TW-1:0] to_ms;
  logic [RW-1:0] retry;
  logic          pend;
  logic          never_run;
  logic          start_q, abort_q;
  logic          done_ok, timeout, retry_go, give_up;

  tick_gen_1ms #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign eng.dht_start = start_q;
  assign eng.dht_abort = abort_q;
  assign eng.dht_en    = enable;
  assign busy          = (state == ARM) || (state == WAIT_DONE);

  // A read is due once the period has elapsed; the very first read after
  // reset is due immediately, and the gap preset lets it through GAP at once.
  always_comb begin
    state_n  = state;
    done_ok  = 1'b0;
    timeout  = 1'b0;
    retry_go = 1'b0;
    give_up  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (gap_ms >= PERIOD_C || never_run || pend || force_req))
          state_n = GAP;
      end
      GAP: begin
        if (!enable)              state_n = IDLE;
        else if (gap_ms >= MIN_C) state_n = ARM;
      end
      ARM: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (eng.dht_done) begin
          done_ok = eng.dht_valid;
          state_n = eng.dht_valid ? IDLE : FAIL;
        end else if (to_ms >= TO_C) begin
          timeout = 1'b1;
          state_n = FAIL;
        end
      end
      FAIL: begin
        retry_go = enable && (retry < RMAX);
        give_up  = enable && (retry >= RMAX);
        state_n  = retry_go ? GAP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gap_ms     <= MIN_C;
      to_ms      <= '0;
      retry      <= '0;
      pend       <= 1'b0;
      never_run  <= 1'b1;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      sample_stb <= 1'b0;
      err_stb    <= 1'b0;
      err_cnt    <= '0;
      data_valid <= 1'b0;
      rh_out     <= '0;
      t_out      <= '0;
    end else begin
      state      <= state_n;
      start_q    <= (state == ARM);
      abort_q    <= timeout;
      sample_stb <= done_ok;
      err_stb    <= give_up;

      if (state == ARM) begin
        gap_ms    <= '0;
        to_ms     <= '0;
        never_run <= 1'b0;
      end else if (tick) begin
        if (gap_ms < PERIOD_C) gap_ms <= gap_ms + 1'b1;
        if (to_ms < TO_C)      to_ms  <= to_ms + 1'b1;
      end

      // A force arriving while busy stays pending until the next start.
      if (!enable)             pend <= 1'b0;
      else if (force_req)      pend <= 1'b1;
      else if (state == ARM)   pend <= 1'b0;

      if (state == FAIL) retry <= retry_go ? retry + 1'b1 : '0;
      else if (done_ok)  retry <= '0;

      if (done_ok) begin
        rh_out     <= eng.dht_rh;
        t_out      <= eng.dht_t;
        data_valid <= 1'b1;
      end

      if (give_up && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
